// File: rtl/prompt_string_decoder_pkg.sv
// Shared definitions for the prompt string decoder and its neighbours.
// The symbol codes are common to the StringRegister, StringGenerator and
// this decoder. The package also holds the default string width and the
// decoder state encoding.
package prompt_string_decoder_pkg;

    localparam int WIDTH_DEF   = 64;
    localparam int MAX_SYM_DEF = 4;
    localparam int CNT_W_DEF   = 6;

    localparam logic [2:0] SYM_NONE   = 3'd0;
    localparam logic [2:0] SYM_TOGGLE = 3'd1;
    localparam logic [2:0] SYM_PUSH   = 3'd2;
    localparam logic [2:0] SYM_MIC    = 3'd3;
    localparam logic [2:0] SYM_MOUSE  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2,
        ST_FIN  = 2'd3
    } dec_state_e;

endpackage

// File: rtl/prompt_string_decoder_scanner.sv
// prompt_bit_scanner: holds the captured string and presents it one bit at
// a time, oldest (MSB) first. It also keeps a count of the bits not yet
// consumed.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset; clears the register and counter
//   load_i  : capture data_i and set the remaining count to WIDTH
//   data_i  : string to capture
//   shift_i : consume the current bit (shift left, decrement remaining)
//   bit_o   : current oldest unconsumed bit
//   last_o  : no bits remain
module prompt_bit_scanner
    import prompt_string_decoder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int REM_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic             bit_o,
    output logic             last_o
);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [REM_W-1:0] rem_q, rem_d;

    always_comb begin
        sr_d  = sr_q;
        rem_d = rem_q;
        if (load_i) begin
            sr_d  = data_i;
            rem_d = REM_W'(WIDTH);
        end else if (shift_i && (rem_q != '0)) begin
            sr_d  = {sr_q[WIDTH-2:0], 1'b0};
            rem_d = rem_q - REM_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_q  <= '0;
            rem_q <= '0;
        end else begin
            sr_q  <= sr_d;
            rem_q <= rem_d;
        end
    end

    assign bit_o  = sr_q[WIDTH-1];
    assign last_o = (rem_q == '0);

endmodule

// File: rtl/prompt_string_decoder.sv
// prompt_string_decoder: decodes a run-length encoded prompt string. A
// symbol k is written as k ones followed by a zero. The decoder streams
// the symbols out over a valid/ready handshake, earliest symbol first.
//   clock     : clock
//   reset     : asynchronous active-high reset
//   load      : start pulse, accepted only when idle
//   bstring   : encoded string, MSB oldest
//   sym_valid : sym holds a decoded symbol
//   sym_ready : consumer accepts sym
//   sym       : symbol code 1..4, 0 when not valid
//   sym_count : symbols handed off since the last load (saturating)
//   busy      : not idle
//   done      : one-cycle pulse on clean completion
//   error     : sticky malformed-encoding flag, cleared by load or reset
module prompt_string_decoder
    import prompt_string_decoder_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MAX_SYM = MAX_SYM_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] bstring,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic [2:0]       sym,
    output logic [CNT_W-1:0] sym_count,
    output logic             busy,
    output logic             done,
    output logic             error
);

    // The run counter has to reach MAX_SYM+1 to flag an overlong run.
    localparam int RUN_W = $clog2(MAX_SYM + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_SYM);

    dec_state_e       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [2:0]       sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic capture, shift, scan_bit, scan_last;

    prompt_bit_scanner #(
        .WIDTH (WIDTH)
    ) u_scanner (
        .clk_i   (clock),
        .rst_i   (reset),
        .load_i  (capture),
        .data_i  (bstring),
        .shift_i (shift),
        .bit_o   (scan_bit),
        .last_o  (scan_last)
    );

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        capture     = 1'b0;
        shift       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    run_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_last) begin
                    // A run still open at end of string has no terminating zero.
                    if (run_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    shift = 1'b1;
                    if (scan_bit) begin
                        run_d = run_q + RUN_W'(1);
                        if (run_q == RUN_MAX) begin
                            err_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (run_q != '0) begin
                        sym_d       = 3'(run_q);
                        sym_valid_d = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (sym_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    sym_d       = SYM_NONE;
                    sym_valid_d = 1'b0;
                    run_d       = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            run_q       <= '0;
            sym_q       <= SYM_NONE;
            sym_valid_q <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign sym_count = cnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign error     = err_q;

endmodule

// File: doc/prompt_string_decoder.md
Name: prompt_string_decoder

Overview:
Reads a 64-bit prompt string in the game's run-length encoding and streams out the symbol sequence, one symbol per valid/ready handshake, earliest symbol first. Each symbol k (1=toggle, 2=push, 3=mic, 4=mouse) is encoded as k ones followed by one zero, appended at the LSB end. Unused MSBs are zero padding. The block sits between the string generator and any consumer that must replay prompts at its own pace, such as a prompt LED sequencer or a checker.

Parameters:
WIDTH, 64, encoded string width in bits.
MAX_SYM, 4, largest legal run length; a longer run is an encoding error.
CNT_W, 6, width of the symbol counter (clog2(WIDTH)).

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
load  in  1  start pulse; captures bstring. Honoured only in IDLE, ignored otherwise.
bstring  in  WIDTH  encoded prompt string, MSB = oldest bit.
sym_valid  out  1  sym holds a decoded symbol.
sym_ready  in  1  consumer accepts sym on a cycle where sym_valid and sym_ready are both high.
sym  out  3  symbol code 1..4; 0 whenever sym_valid is low.
sym_count  out  CNT_W  number of symbols handed off since the last load.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse: string fully consumed without error.
error  out  1  sticky until the next accepted load or reset: malformed encoding.

Behaviour:
- Reset (async, any state) forces IDLE and clears the shift register and the remaining-bit counter. All outputs go to 0.
- States: IDLE, SCAN, EMIT, FIN.
- IDLE + load: on that edge the block captures bstring into the shift register, sets remaining=WIDTH, run=0 and sym_count=0, clears error, and moves to SCAN.
- SCAN consumes one bit per clock (shift register MSB, then shift left; remaining decrements by 1).
  - Bit=1: run increments. If run becomes MAX_SYM+1, set error and go to IDLE.
  - Bit=0 with run=0: the bit is skipped as padding.
  - Bit=0 with run>0: register sym=run, set sym_valid=1, go to EMIT.
  - SCAN with remaining=0 and run=0: go to FIN.
  - SCAN with remaining=0 and run>0: the run is unterminated; set error and go to IDLE.
- EMIT holds sym and sym_valid stable while sym_ready is low. On handshake: sym_count increments, sym_valid drops, run=0, return to SCAN.
- FIN drives done=1 for exactly one cycle, then goes to IDLE.
- Latency: one clock per string bit plus one cycle per handshake. For the 64-bit string 0x2 ("10"), load at edge t0 gives sym_valid high after edge t64.
- sym_ready is ignored outside EMIT.
- load during SCAN, EMIT or FIN has no effect.
- error and done are never high together.
- sym_count saturates at 2^CNT_W-1. This is unreachable at WIDTH=64, where the maximum is 32 symbols.

Decomposition:
- Shared package holds:
  - Symbol constants SYM_NONE=0, SYM_TOGGLE=1, SYM_PUSH=2, SYM_MIC=3, SYM_MOUSE=4.
  - The WIDTH default.
  - Decoder state encodings.
  - The StringRegister and StringGenerator use the same symbol constants.
- One sub-module, prompt_bit_scanner, contains:
  - the WIDTH-bit shift register;
  - the remaining-bit down-counter;
  - a bit/last output.
- The top level keeps the FSM, the run counter and the output registers.

Test Plan:
1. bstring=0x16 ("10"+"110"), load, sym_ready tied high -> sym=1, then sym=2, then done pulse; sym_count=2; error=0.
2. bstring=0x1E ("11110"), sym_ready low for 5 cycles after sym_valid rises -> sym=4 held stable all 5 cycles; one handshake; sym_count=1; done.
3. bstring=0 -> no sym_valid, done pulse 65 cycles after load, sym_count=0.
4. bstring=0x3E (run of 5) -> error=1 and busy=0, no symbol emitted; a later load of 0x2 clears error and emits sym=1.
5. bstring=0x5 ("101", trailing unterminated run) -> sym=1 emitted, then error=1 at end of string, no done.
6. Assert reset during EMIT, then apply load while busy in a second run -> all outputs 0 immediately on reset; the load while busy is ignored, and the original decode completes unchanged.
